// File: rtl/wb_stage_pkg.sv
// Shared constants for the write-back stage: MEM->WB bus layout, CP0 map and exception codes.
package wb_stage_pkg;

  localparam int unsigned MEM_WB_W       = 118;
  localparam int unsigned RF_WEN_BIT     = 117;
  localparam int unsigned RF_WDEST_LSB   = 112;
  localparam int unsigned MEM_RESULT_LSB = 80;
  localparam int unsigned LO_RESULT_LSB  = 48;
  localparam int unsigned HI_WRITE_BIT   = 47;
  localparam int unsigned LO_WRITE_BIT   = 46;
  localparam int unsigned MFHI_BIT       = 45;
  localparam int unsigned MFLO_BIT       = 44;
  localparam int unsigned MTC0_BIT       = 43;
  localparam int unsigned MFC0_BIT       = 42;
  localparam int unsigned CP0_ADDR_LSB   = 34;
  localparam int unsigned SYSCALL_BIT    = 33;
  localparam int unsigned ERET_BIT       = 32;
  localparam int unsigned PC_LSB         = 0;

  // CP0 addresses are {rd[4:0], sel[2:0]}
  localparam logic [7:0] CP0_STATUS_ADDR = 8'h60;
  localparam logic [7:0] CP0_CAUSE_ADDR  = 8'h68;
  localparam logic [7:0] CP0_EPC_ADDR    = 8'h70;

  localparam logic [4:0]  EXC_CODE_SYSCALL = 5'd8;
  localparam logic [31:0] EXC_ENTRY        = 32'h0000_0008;

  localparam int unsigned STATUS_EXL_BIT = 1;
  localparam int unsigned CAUSE_EXC_LSB  = 2;

  typedef struct packed {
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] mem_result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        eret;
    logic [31:0] pc;
  } mem_wb_t;

  function automatic mem_wb_t decode_bus(input logic [MEM_WB_W-1:0] b);
    mem_wb_t f;
    f.rf_wen     = b[RF_WEN_BIT];
    f.rf_wdest   = b[RF_WDEST_LSB +: 5];
    f.mem_result = b[MEM_RESULT_LSB +: 32];
    f.lo_result  = b[LO_RESULT_LSB +: 32];
    f.hi_write   = b[HI_WRITE_BIT];
    f.lo_write   = b[LO_WRITE_BIT];
    f.mfhi       = b[MFHI_BIT];
    f.mflo       = b[MFLO_BIT];
    f.mtc0       = b[MTC0_BIT];
    f.mfc0       = b[MFC0_BIT];
    f.cp0r_addr  = b[CP0_ADDR_LSB +: 8];
    f.syscall    = b[SYSCALL_BIT];
    f.eret       = b[ERET_BIT];
    f.pc         = b[PC_LSB +: 32];
    return f;
  endfunction

endpackage

// File: rtl/wb_stage_cp0_regs.sv
// CP0 STATUS/CAUSE/EPC storage with syscall/eret/mtc0 update and the mfc0 read mux.
module cp0_regs
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic        mtc0,
  input  logic        syscall,
  input  logic        eret,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        exc_valid,
  output logic [31:0] exc_pc
);

  logic        exl_q,  exl_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q,  epc_d;

  // Next-state: syscall beats eret, and both beat an mtc0 in the same instruction
  always_comb begin
    exl_d  = exl_q;
    code_d = code_q;
    epc_d  = epc_q;
    if (wb_valid) begin
      if (syscall) begin
        epc_d  = pc;
        code_d = EXC_CODE_SYSCALL;
        exl_d  = 1'b1;
      end else if (eret) begin
        exl_d = 1'b0;
      end else if (mtc0) begin
        case (addr)
          CP0_STATUS_ADDR: exl_d  = wdata[STATUS_EXL_BIT];
          CP0_CAUSE_ADDR:  code_d = wdata[CAUSE_EXC_LSB +: 5];
          CP0_EPC_ADDR:    epc_d  = wdata;
          default:         epc_d  = epc_q;
        endcase
      end else begin
        exl_d = exl_q;
      end
    end else begin
      exl_d = exl_q;
    end
  end

  // CP0 state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exl_q  <= 1'b0;
      code_q <= 5'd0;
      epc_q  <= 32'h0;
    end else begin
      exl_q  <= exl_d;
      code_q <= code_d;
      epc_q  <= epc_d;
    end
  end

  // Read mux and redirect target; unimplemented bits and addresses read as zero
  always_comb begin
    rdata = 32'h0;
    case (addr)
      CP0_STATUS_ADDR: rdata[STATUS_EXL_BIT] = exl_q;
      CP0_CAUSE_ADDR:  rdata[CAUSE_EXC_LSB +: 5] = code_q;
      CP0_EPC_ADDR:    rdata = epc_q;
      default:         rdata = 32'h0;
    endcase
    exc_valid = wb_valid & (syscall | eret);
    if (!exc_valid) begin
      exc_pc = 32'h0;
    end else if (syscall) begin
      exc_pc = EXC_ENTRY;
    end else begin
      exc_pc = epc_q;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: HI/LO ownership, register-file write port, CP0 and exception redirect.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                WB_valid,
  input  logic [MEM_WB_W-1:0] MEM_WB_bus_r,
  output logic                rf_wen,
  output logic [4:0]          rf_wdest,
  output logic [31:0]         rf_wdata,
  output logic                WB_over,
  output logic [4:0]          WB_wdest,
  output logic [32:0]         exc_bus,
  output logic                cancel,
  output logic [31:0]         WB_pc,
  output logic [31:0]         hi_out,
  output logic [31:0]         lo_out
);

  mem_wb_t     wb_s;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] cp0_rdata_s;
  logic        exc_valid_s;
  logic [31:0] exc_pc_s;

  assign wb_s = decode_bus(MEM_WB_bus_r);

  // HI/LO next state; MULT sets both writes at once
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (WB_valid) begin
      if (wb_s.hi_write) begin
        hi_d = wb_s.mem_result;
      end else begin
        hi_d = hi_q;
      end
      if (wb_s.lo_write) begin
        lo_d = wb_s.lo_result;
      end else begin
        lo_d = lo_q;
      end
    end else begin
      hi_d = hi_q;
    end
  end

  // HI/LO registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= 32'h0;
      lo_q <= 32'h0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  cp0_regs u_cp0_regs (
    .clk       (clk),
    .rst       (rst),
    .wb_valid  (WB_valid),
    .mtc0      (wb_s.mtc0),
    .syscall   (wb_s.syscall),
    .eret      (wb_s.eret),
    .addr      (wb_s.cp0r_addr),
    .wdata     (wb_s.mem_result),
    .pc        (wb_s.pc),
    .rdata     (cp0_rdata_s),
    .exc_valid (exc_valid_s),
    .exc_pc    (exc_pc_s)
  );

  // Write-back data mux; reads see registered values so the previous write is visible
  always_comb begin
    if (wb_s.mfhi) begin
      rf_wdata = hi_q;
    end else if (wb_s.mflo) begin
      rf_wdata = lo_q;
    end else if (wb_s.mfc0) begin
      rf_wdata = cp0_rdata_s;
    end else begin
      rf_wdata = wb_s.mem_result;
    end
  end

  assign rf_wen   = WB_valid & wb_s.rf_wen & ~wb_s.syscall & ~wb_s.eret;
  assign rf_wdest = wb_s.rf_wdest;
  assign WB_wdest = wb_s.rf_wdest & {5{WB_valid}};
  assign WB_over  = WB_valid;
  assign exc_bus  = {exc_valid_s, exc_pc_s};
  assign cancel   = exc_valid_s;
  assign WB_pc    = wb_s.pc;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed scenarios then randomized instructions vs a behavioural model.
module tb_wb_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         wb_valid;
  logic [117:0] bus;
  logic         rf_wen, wb_over, cancel;
  logic [4:0]   rf_wdest, wb_wdest;
  logic [31:0]  rf_wdata, wb_pc, hi_out, lo_out;
  logic [32:0]  exc_bus;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .WB_valid(wb_valid), .MEM_WB_bus_r(bus),
    .rf_wen(rf_wen), .rf_wdest(rf_wdest), .rf_wdata(rf_wdata), .WB_over(wb_over),
    .WB_wdest(wb_wdest), .exc_bus(exc_bus), .cancel(cancel), .WB_pc(wb_pc),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  typedef struct {
    logic        rf_wen;
    logic [4:0]  wdest;
    logic [31:0] mem;
    logic [31:0] lor;
    logic        hw, lw, mfhi, mflo, mtc0, mfc0;
    logic [7:0]  addr;
    logic        sys, eret;
    logic [31:0] pc;
  } instr_t;

  typedef struct {
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] rf_wdata;
    logic        wb_over;
    logic [4:0]  wb_wdest;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic        cancel;
    logic [31:0] wb_pc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];

  // Architectural model state
  logic [31:0] m_hi, m_lo, m_epc;
  logic        m_exl;
  logic [4:0]  m_code;

  function automatic logic [117:0] pack(input instr_t i);
    return {i.rf_wen, i.wdest, i.mem, i.lor, i.hw, i.lw, i.mfhi, i.mflo,
            i.mtc0, i.mfc0, i.addr, i.sys, i.eret, i.pc};
  endfunction

  function automatic logic [31:0] cp0_read(input logic [7:0] a);
    if (a == 8'h60) return {30'd0, m_exl, 1'b0};
    if (a == 8'h68) return {25'd0, m_code, 2'b00};
    if (a == 8'h70) return m_epc;
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_hi = 32'h0; m_lo = 32'h0; m_epc = 32'h0; m_exl = 1'b0; m_code = 5'd0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one WB cycle, push the expected response, then advance the model
  task automatic issue(input logic v, input instr_t i, input logic r);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    wb_valid = v;
    bus = pack(i);
    if (r) model_reset();
    e.exc_valid = v & (i.sys | i.eret);
    e.exc_pc    = !e.exc_valid ? 32'h0 : (i.sys ? 32'h8 : m_epc);
    e.cancel    = e.exc_valid;
    e.rf_wen    = v & i.rf_wen & ~i.sys & ~i.eret;
    e.rf_wdest  = i.wdest;
    e.wb_wdest  = v ? i.wdest : 5'd0;
    e.wb_over   = v;
    e.wb_pc     = i.pc;
    e.hi        = m_hi;
    e.lo        = m_lo;
    e.rf_wdata  = i.mfhi ? m_hi : i.mflo ? m_lo : i.mfc0 ? cp0_read(i.addr) : i.mem;
    sb.push_back(e);
    if (v && !r) begin
      if (i.hw) m_hi = i.mem;
      if (i.lw) m_lo = i.lor;
      if (i.sys) begin
        m_epc = i.pc; m_code = 5'd8; m_exl = 1'b1;
      end else if (i.eret) begin
        m_exl = 1'b0;
      end else if (i.mtc0) begin
        if (i.addr == 8'h60) m_exl = i.mem[1];
        else if (i.addr == 8'h68) m_code = i.mem[6:2];
        else if (i.addr == 8'h70) m_epc = i.mem;
      end
    end
  endtask

  // Monitor: compare every presented cycle against the oldest expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("rf_wen",    {31'd0, rf_wen},      {31'd0, e.rf_wen});
      chk("rf_wdest",  {27'd0, rf_wdest},    {27'd0, e.rf_wdest});
      chk("rf_wdata",  rf_wdata,             e.rf_wdata);
      chk("WB_over",   {31'd0, wb_over},     {31'd0, e.wb_over});
      chk("WB_wdest",  {27'd0, wb_wdest},    {27'd0, e.wb_wdest});
      chk("exc_valid", {31'd0, exc_bus[32]}, {31'd0, e.exc_valid});
      chk("exc_pc",    exc_bus[31:0],        e.exc_pc);
      chk("cancel",    {31'd0, cancel},      {31'd0, e.cancel});
      chk("WB_pc",     wb_pc,                e.wb_pc);
      chk("hi_out",    hi_out,               e.hi);
      chk("lo_out",    lo_out,               e.lo);
    end
  end

  function automatic instr_t nop();
    instr_t i;
    i = '{rf_wen: 1'b0, wdest: 5'd0, mem: 32'h0, lor: 32'h0, hw: 1'b0, lw: 1'b0,
          mfhi: 1'b0, mflo: 1'b0, mtc0: 1'b0, mfc0: 1'b0, addr: 8'h0,
          sys: 1'b0, eret: 1'b0, pc: 32'h0};
    return i;
  endfunction

  function automatic instr_t mfc0_i(input logic [7:0] a);
    instr_t i;
    i = nop(); i.mfc0 = 1'b1; i.addr = a; i.rf_wen = 1'b1; i.wdest = 5'd9; i.pc = 32'h200;
    return i;
  endfunction

  initial begin
    instr_t i;
    rst = 1'b1;
    wb_valid = 1'b0;
    bus = '0;
    model_reset();
    #1;
    chk("reset hi_out", hi_out, 32'h0);
    chk("reset lo_out", lo_out, 32'h0);
    chk("reset exc_bus", exc_bus[31:0], 32'h0);
    issue(1'b1, mfc0_i(8'h70), 1'b1);
    issue(1'b0, nop(), 1'b0);

    // HI/LO round trip
    i = nop(); i.hw = 1'b1; i.lw = 1'b1; i.mem = 32'h1234_5678; i.lor = 32'h9ABC_DEF0; i.pc = 32'h10;
    issue(1'b1, i, 1'b0);
    i = nop(); i.mfhi = 1'b1; i.rf_wen = 1'b1; i.wdest = 5'd2; i.mem = 32'h5555_AAAA; i.pc = 32'h14;
    issue(1'b1, i, 1'b0);
    i = nop(); i.mflo = 1'b1; i.rf_wen = 1'b1; i.wdest = 5'd3; i.pc = 32'h18;
    issue(1'b1, i, 1'b0);

    // SYSCALL, then read back EPC/CAUSE/STATUS
    i = nop(); i.sys = 1'b1; i.rf_wen = 1'b1; i.wdest = 5'd4; i.pc = 32'h0000_0040;
    i.mtc0 = 1'b1; i.addr = 8'h70; i.mem = 32'hDEAD_BEEF;
    issue(1'b1, i, 1'b0);
    issue(1'b1, mfc0_i(8'h70), 1'b0);
    issue(1'b1, mfc0_i(8'h68), 1'b0);
    issue(1'b1, mfc0_i(8'h60), 1'b0);

    // ERET after MTC0 EPC
    i = nop(); i.mtc0 = 1'b1; i.addr = 8'h70; i.mem = 32'h0000_0100; i.pc = 32'h44;
    issue(1'b1, i, 1'b0);
    i = nop(); i.eret = 1'b1; i.rf_wen = 1'b1; i.wdest = 5'd5; i.pc = 32'h48;
    issue(1'b1, i, 1'b0);
    issue(1'b1, mfc0_i(8'h60), 1'b0);

    // Invalid cycle must not touch any state
    i = nop(); i.hw = 1'b1; i.mem = 32'hDEAD_0001; i.sys = 1'b1; i.rf_wen = 1'b1; i.wdest = 5'd7;
    issue(1'b0, i, 1'b0);
    i = nop(); i.mfhi = 1'b1; i.rf_wen = 1'b1; i.wdest = 5'd6;
    issue(1'b1, i, 1'b0);
    issue(1'b1, mfc0_i(8'h70), 1'b0);

    // Unknown CP0 address
    i = nop(); i.mtc0 = 1'b1; i.addr = 8'h08; i.mem = 32'hFFFF_FFFF;
    issue(1'b1, i, 1'b0);
    issue(1'b1, mfc0_i(8'h08), 1'b0);
    issue(1'b1, mfc0_i(8'h60), 1'b0);
    issue(1'b1, mfc0_i(8'h68), 1'b0);
    issue(1'b1, mfc0_i(8'h70), 1'b0);

    // Async reset between edges
    i = nop(); i.hw = 1'b1; i.mem = 32'hFFFF_FFFF;
    issue(1'b1, i, 1'b0);
    issue(1'b0, nop(), 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async hi_out", hi_out, 32'h0);
    i = nop(); i.mfhi = 1'b1; i.rf_wen = 1'b1; i.wdest = 5'd8;
    issue(1'b1, i, 1'b1);
    issue(1'b0, nop(), 1'b0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      i.rf_wen = 1'($urandom);
      i.wdest  = 5'($urandom);
      i.mem    = $urandom;
      i.lor    = $urandom;
      i.hw     = ($urandom_range(0, 3) == 0);
      i.lw     = ($urandom_range(0, 3) == 0);
      i.mfhi   = ($urandom_range(0, 4) == 0);
      i.mflo   = ($urandom_range(0, 4) == 0);
      i.mtc0   = ($urandom_range(0, 3) == 0);
      i.mfc0   = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: i.addr = 8'h60;
        1: i.addr = 8'h68;
        2: i.addr = 8'h70;
        default: i.addr = 8'($urandom);
      endcase
      i.sys  = ($urandom_range(0, 7) == 0);
      i.eret = ($urandom_range(0, 7) == 0);
      i.pc   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      issue(($urandom_range(0, 4) != 0), i, 1'b0);
    end

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage pipeline CPU, directly downstream of the memory-access stage. It consumes the 118-bit MEM->WB bus and drives the register-file write port. It owns the HI/LO registers and the CP0 registers STATUS, CAUSE and EPC. It turns SYSCALL/ERET into a redirect request for the fetch stage, plus a pipeline cancel.

## Interface
- EXC_ENTRY, 32'h0000_0008: PC loaded on SYSCALL.
- SYSCALL_CODE, 5'd8: ExcCode written to CAUSE[6:2] on SYSCALL.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- WB_valid  in  1  the WB stage holds a valid instruction this cycle.
- MEM_WB_bus_r  in  118  registered MEM->WB bus, MSB first:
  - rf_wen[117], rf_wdest[116:112], mem_result[111:80], lo_result[79:48]
  - hi_write[47], lo_write[46], mfhi[45], mflo[44], mtc0[43], mfc0[42]
  - cp0r_addr[41:34], syscall[33], eret[32], pc[31:0]
- rf_wen  out  1  register-file write enable.
- rf_wdest  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- WB_over  out  1  WB finished this cycle.
- WB_wdest  out  5  destination register for hazard detection.
- exc_bus  out  33  {exc_valid, exc_pc}: redirect request to fetch.
- cancel  out  1  flushes IF/ID/EXE/MEM.
- WB_pc  out  32  PC shown on the display.
- hi_out, lo_out  out  32 each  current HI/LO, for the display.

## Operation
- Any state update requires WB_valid=1; with WB_valid=0 no register changes.
- CP0 address encoding is {rd[4:0], sel[2:0]}:
  - STATUS = 8'h60; only bit EXL[1] is writable, all other bits read 0.
  - CAUSE = 8'h68; only ExcCode[6:2] is stored, all other bits read 0.
  - EPC = 8'h70; full 32 bits.
  - Any other address: mtc0 is ignored, mfc0 returns 0.
- HI/LO:
  - hi_write: HI <= mem_result.
  - lo_write: LO <= lo_result.
  - Both may be set in one instruction (MULT).
- mtc0: selected CP0 register <= mem_result, where mem_result carries rt.
- syscall, in priority order over mtc0 in the same instruction:
  - EPC <= pc, CAUSE.ExcCode <= SYSCALL_CODE, STATUS.EXL <= 1.
  - exc_valid = 1, exc_pc = EXC_ENTRY.
- eret:
  - STATUS.EXL <= 0.
  - exc_valid = 1, exc_pc = the EPC register value at that moment (pre-edge).
- Write data mux, priority in this order: mfhi -> HI; mflo -> LO; mfc0 -> CP0 read; otherwise mem_result. HI/LO/CP0 reads return the registered value, so a write by the previous instruction is visible.
- rf_wen = WB_valid & rf_wen_field & ~syscall & ~eret.
- WB_wdest = rf_wdest & {5{WB_valid}}.
- WB_over = WB_valid.
- cancel = exc_valid, where exc_valid = WB_valid & (syscall | eret).
- When exc_valid=0, exc_pc is driven 0.
- WB_pc = pc.

## Timing
- All outputs are combinational from WB_valid, the bus and the current registers; zero added latency. WB completes in one cycle.
- HI, LO, STATUS, CAUSE and EPC update on the edge that ends the valid WB cycle. A new value is first readable by the next instruction in WB.
- Reset values: HI = LO = STATUS = CAUSE = EPC = 0.
- Reset mid-operation: registers clear immediately, without waiting for a clock edge. All combinational outputs follow the cleared values, so mfhi reads 0 while rst is high.
- syscall and eret both set (illegal encoding): syscall wins, eret is ignored.
- ERET with EXL=0 still redirects to EPC; no check is made.
- exc_valid and cancel are single-cycle pulses per valid WB instruction. The fetch stage takes the redirect on the same edge.

## Structure
- Shared package holds:
  - bus width constant 118 and the bus field offsets;
  - CP0 addresses 8'h60/8'h68/8'h70;
  - ExcCode constants;
  - the STATUS.EXL bit index.
- One sub-module, cp0_regs: STATUS/CAUSE/EPC storage, read mux, and syscall/eret/mtc0 update logic.
- HI/LO and the write-back mux stay in wb_stage.

## Test plan
- HI/LO round trip:
  - Stimulus: valid MULT with hi_write=lo_write=1, mem_result=32'h1234_5678, lo_result=32'h9ABC_DEF0; then mfhi to r2; then mflo to r3.
  - Required: HI/LO hold those values after the first edge; r2 is written 32'h1234_5678, r3 is written 32'h9ABC_DEF0.
- SYSCALL:
  - Stimulus: syscall at pc=32'h0000_0040.
  - Required: exc_valid=1, exc_pc=32'h8, cancel=1, rf_wen=0; next cycle EPC=32'h40, CAUSE=32'h20, STATUS=32'h2.
- ERET after MTC0:
  - Stimulus: mtc0 EPC=32'h0000_0100, then eret.
  - Required: exc_pc=32'h100; STATUS.EXL=0 afterwards.
- Invalid cycle:
  - Stimulus: WB_valid=0 with hi_write=1, syscall=1, rf_wen=1.
  - Required: rf_wen=0, exc_valid=0, WB_wdest=0, HI unchanged.
- Async reset:
  - Stimulus: assert rst between edges after HI=32'hFFFF_FFFF; then issue mfhi with rst high.
  - Required: hi_out=0 before the next edge; mfhi reads 0.
- Unknown CP0 address:
  - Stimulus: mtc0 to 8'h08, then mfc0 from 8'h08.
  - Required: rf_wdata=0; STATUS, CAUSE and EPC unchanged.
